// File: rtl/wb_uart_tx_pkg.sv
// wb_uart_tx_pkg: shared definitions for the Wishbone UART transmitter.
//   - register offsets, status bit positions, TX FSM encodings, reset divisor
//   - WB_UART_TX_PARITY_EN (optional): adds an even-parity bit after the data
//     bits and reports it in status bit 7.
package wb_uart_tx_pkg;

  localparam logic [31:0] REG_DATA = 32'h0;
  localparam logic [31:0] REG_DIV  = 32'h4;

  // Status register bit positions
  localparam int ST_BUSY   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_ACTIVE = 3;
  localparam int ST_OVF    = 4;
  localparam int ST_PAR    = 7;

  // 100 MHz / 115200 baud
  localparam int UART_DEFAULT_DIV = 868;

`ifdef WB_UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } tx_state_e;
`else
  localparam logic PARITY_EN = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/wb_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO, W bits wide, 2**AW entries deep.
//   clk/rst          : clock, synchronous active-high reset (flushes)
//   push/din         : write request and data (dropped when full, unless a
//                      pop in the same cycle frees a slot)
//   pop/dout         : read request; dout shows the head entry combinationally
//   full/empty/count : occupancy, count in 0..2**AW
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = count_q[AW];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // a same-cycle pop frees a slot, so a push into a full FIFO still lands
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-style slave UART transmitter (8N1, optional parity).
//   clk, rst         : system clock, synchronous active-high reset
//   dat_i/adr_i/we_i/stb_i : bus request; only adr_i[2] is decoded
//   dat_o, ack_o     : registered read data and acknowledge
//   tx               : serial line, idle high
//   busy             : FIFO non-empty or frame in flight
// Registers: adr[2]=0 write pushes a byte, read returns status (clears
// overflow); adr[2]=1 accesses the baud divisor (0 is stored as 1).
// Optional: WB_UART_TX_PARITY_EN adds an even-parity bit before STOP.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dat_i,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        tx,
  output logic        busy
);
  tx_state_e        state_q, state_d;
  logic             stb_q;
  logic [31:0]      dat_o_q, dat_o_d;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;
`ifdef WB_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             start, sel_div, push;
  logic             fifo_pop, fifo_full, fifo_empty, load;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_count;
  logic             tx_active, baud_done;
  logic [31:0]      status;
  logic             unused;

  assign unused = ^{adr_i[31:3], adr_i[1:0], dat_i[31:DIV_W]};

  // side effects fire only on the first cycle of a strobe
  assign start     = stb_i & ~stb_q;
  assign sel_div   = adr_i[2];
  assign push      = start & we_i & ~sel_div;
  assign tx_active = (state_q != S_IDLE);
  assign busy      = tx_active | ~fifo_empty;
  assign baud_done = (baud_q == '0);
  assign ack_o     = stb_q;
  assign dat_o     = dat_o_q;
  assign tx        = tx_q;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dat_i[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus side: register file, status, overflow
  always_comb begin
    status            = '0;
    status[15:8]      = 8'(fifo_count);
    status[ST_PAR]    = PARITY_EN;
    status[ST_OVF]    = ovf_q;
    status[ST_ACTIVE] = tx_active;
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_BUSY]   = busy;

    dat_o_d   = dat_o_q;
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    if (start) begin
      dat_o_d = sel_div ? 32'(divisor_q) : status;
      if (!we_i && !sel_div) ovf_d = 1'b0;
      if (we_i && sel_div)
        divisor_d = (dat_i[DIV_W-1:0] == '0) ? DIV_W'(1) : dat_i[DIV_W-1:0];
    end
    // drop only when the FSM is not freeing a slot this same cycle
    if (push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // TX engine
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_done ? baud_q : baud_q - DIV_W'(1);
    div_d    = div_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE:  if (!fifo_empty) load = 1'b1;
      S_START: if (baud_done) begin
        state_d = S_DATA;
        baud_d  = div_q - DIV_W'(1);
      end
      S_DATA:  if (baud_done) begin
        baud_d  = div_q - DIV_W'(1);
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
`ifdef WB_UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = S_PARITY;
`else
        if (bit_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef WB_UART_TX_PARITY_EN
      S_PARITY: if (baud_done) begin
        state_d = S_STOP;
        baud_d  = div_q - DIV_W'(1);
      end
`endif
      // back-to-back: reload straight into START without an idle cycle
      S_STOP:  if (baud_done) begin
        if (!fifo_empty) load = 1'b1;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // divisor is sampled per frame so mid-frame writes wait for the next byte
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      div_d    = divisor_q;
      baud_d   = divisor_q - DIV_W'(1);
      bit_d    = 3'd0;
      state_d  = S_START;
`ifdef WB_UART_TX_PARITY_EN
      par_d    = ^fifo_dout;
`endif
    end

    // tx is registered from next-state values so the pin is glitch-free
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef WB_UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stb_q     <= 1'b0;
      dat_o_q   <= '0;
      ovf_q     <= 1'b0;
      divisor_q <= DIV_W'(DEFAULT_DIV);
      div_q     <= DIV_W'(DEFAULT_DIV);
      baud_q    <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
`ifdef WB_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_i;
      dat_o_q   <= dat_o_d;
      ovf_q     <= ovf_d;
      divisor_q <= divisor_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
`ifdef WB_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
